// File: rtl/pwm_from_count6.sv
// pwm_from_count6
//   PWM generator driven by an upstream free-running 6-bit counter. A new
//   duty value is accepted into a shadow register through a valid/ready
//   handshake. It becomes the active duty only at a period boundary, which is
//   the cycle where cnt returns to 0 from a non-zero value.
//
//   Optional feature: define PWM6_WRAP_PULSE_EN to add the wrap_p output.
//   wrap_p is a 1-cycle registered pulse after each boundary seen in RUN or
//   STOP.
//
// Ports
//   clk         rising-edge clock, shared with the upstream counter
//   rst         asynchronous active-low reset
//   cnt[5:0]    upstream free-running count
//   en          run request
//   duty[5:0]   offered duty (high counts per 64-count period)
//   duty_valid  duty offer strobe
//   duty_ready  shadow register free (= !pending)
//   pwm         registered PWM output
//   busy        registered, high whenever the FSM is not IDLE
//   wrap_p      period-start pulse (PWM6_WRAP_PULSE_EN only)
module pwm_from_count6 (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] cnt,
    input  logic       en,
    input  logic [5:0] duty,
    input  logic       duty_valid,
    output logic       duty_ready,
    output logic       pwm,
`ifdef PWM6_WRAP_PULSE_EN
    output logic       busy,
    output logic       wrap_p
`else
    output logic       busy
`endif
);

    typedef enum logic [1:0] {IDLE, ARMED, RUN, STOP} state_t;

    state_t     state;
    state_t     state_next;
    logic [5:0] cnt_q;
    logic [5:0] shadow;
    logic [5:0] duty_act;
    logic [5:0] duty_act_next;
    logic       pending;
    logic       boundary;
    logic       transfer;
    logic       active_next;

    // cnt_q resets to 0, so a count parked at 0 across reset release is not a
    // boundary. cnt must leave 0 and come back before a boundary is seen.
    assign boundary   = (cnt == 6'd0) && (cnt_q != 6'd0);
    assign duty_ready = !pending;
    assign transfer   = duty_valid && !pending;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (en) state_next = ARMED;
            ARMED: if (!en) state_next = IDLE;
                   else if (boundary) state_next = RUN;
            RUN:   if (!en) state_next = STOP;
            STOP:  if (en) state_next = RUN;
                   else if (boundary) state_next = IDLE;
        endcase
    end

    // The shadow is loaded after the boundary check. A transfer landing on a
    // boundary therefore waits one full period before it takes effect.
    assign duty_act_next = (boundary && pending) ? shadow : duty_act;
    assign active_next   = (state_next == RUN) || (state_next == STOP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt_q    <= '0;
            shadow   <= '0;
            duty_act <= '0;
            pending  <= 1'b0;
            pwm      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            cnt_q    <= cnt;
            duty_act <= duty_act_next;
            if (transfer) begin
                shadow  <= duty;
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
            pwm  <= active_next && (cnt < duty_act_next);
            busy <= (state_next != IDLE);
        end
    end

`ifdef PWM6_WRAP_PULSE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_p <= 1'b0;
        end else begin
            wrap_p <= boundary && ((state == RUN) || (state == STOP));
        end
    end
`else
`endif

endmodule

// File: tb/tb_pwm_from_count6.sv
// Bench for pwm_from_count6. A behavioural reference model is updated on
// every clock edge and on reset. A single compare process checks all outputs
// on each falling edge. Directed periods pin the model with literal
// high-cycle counts, and a randomized phase follows.
module tb_pwm_from_count6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] cnt = '0;
    logic       en = 1'b0;
    logic [5:0] duty = '0;
    logic       duty_valid = 1'b0;
    logic       duty_ready;
    logic       pwm;
    logic       busy;
`ifdef PWM6_WRAP_PULSE_EN
    logic       wrap_p;
`endif

    int vectors = 0;
    int miscompares = 0;

    pwm_from_count6 dut (
        .clk        (clk),
        .rst        (rst),
        .cnt        (cnt),
        .en         (en),
        .duty       (duty),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .pwm        (pwm),
`ifdef PWM6_WRAP_PULSE_EN
        .busy       (busy),
        .wrap_p     (wrap_p)
`else
        .busy       (busy)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=idle 1=armed 2=run 3=stop
    int m_mode = 0, m_prev = 0, m_shadow = 0, m_act = 0;
    bit m_pend = 0, m_pwm = 0, m_busy = 0, m_wrap = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = 0; m_prev = 0; m_shadow = 0; m_act = 0;
            m_pend = 0; m_pwm = 0; m_busy = 0; m_wrap = 0;
        end else begin
            int  c;
            bit  bnd, was_running, had_pend;
            c           = int'(cnt);
            bnd         = (c == 0) && (m_prev != 0);
            was_running = (m_mode >= 2);
            had_pend    = m_pend;
            case (m_mode)
                0: if (en) m_mode = 1;
                1: m_mode = !en ? 0 : (bnd ? 2 : 1);
                2: if (!en) m_mode = 3;
                default: m_mode = en ? 2 : (bnd ? 0 : 3);
            endcase
            if (bnd && had_pend) begin
                m_act  = m_shadow;
                m_pend = 0;
            end
            if (duty_valid && !had_pend) begin
                m_shadow = int'(duty);
                m_pend   = 1;
            end
            m_pwm  = (m_mode >= 2) && (c < m_act);
            m_busy = (m_mode != 0);
            m_wrap = bnd && was_running;
            m_prev = c;
        end
    end

    always @(negedge clk) begin
        chk("pwm", int'(pwm), int'(m_pwm));
        chk("busy", int'(busy), int'(m_busy));
        chk("duty_ready", int'(duty_ready), int'(!m_pend));
`ifdef PWM6_WRAP_PULSE_EN
        chk("wrap_p", int'(wrap_p), int'(m_wrap));
`endif
    end

    task automatic cyc(input int c, input bit e, input int d, input bit dv);
        @(posedge clk);
        #2;
        cnt        = 6'(c);
        en         = e;
        duty       = 6'(d);
        duty_valid = dv;
    endtask

    // One full 0..63 sweep. Duty 'offer' is strobed at cnt=10 when dv is set.
    // The window of 64 samples is offset by one cycle of pwm latency.
    task automatic run_period(input int offer, input bit dv, output int highs, output int wraps);
        highs = 0;
        wraps = 0;
        for (int c = 0; c < 64; c++) begin
            cyc(c, 1'b1, offer, dv && (c == 10));
            @(negedge clk);
            highs += int'(pwm);
`ifdef PWM6_WRAP_PULSE_EN
            wraps += int'(wrap_p);
`endif
        end
    endtask

    initial begin
        int h, w, cv;
        bit ev;

        #3;
        chk("reset_pwm", int'(pwm), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ready", int'(duty_ready), 1);
        @(posedge clk); #2 rst = 1'b1;

        cyc(0, 1'b0, 0, 1'b0);
        cyc(0, 1'b0, 16, 1'b1);
        cyc(0, 1'b0, 0, 1'b0);
        @(negedge clk);
        chk("idle_pending_ready", int'(duty_ready), 0);
        chk("idle_busy", int'(busy), 0);
        h = 0;
        for (int c = 1; c < 64; c++) begin
            cyc(c, 1'b1, 0, 1'b0);
            @(negedge clk);
            h += int'(pwm);
        end
        chk("armed_busy", int'(busy), 1);
        chk("armed_highs", h, 0);

        run_period(0, 1'b0, h, w);
        chk("first_period_highs16", h, 16);
        chk("ready_after_apply", int'(duty_ready), 1);
        run_period(63, 1'b1, h, w);
        chk("offer_period_keeps16", h, 16);
`ifdef PWM6_WRAP_PULSE_EN
        chk("wrap_pulses_per_period", w, 1);
`endif
        run_period(0, 1'b1, h, w);
        chk("duty63_highs", h, 63);
        run_period(16, 1'b1, h, w);
        chk("duty0_highs", h, 0);
        run_period(0, 1'b0, h, w);
        chk("duty16_again", h, 16);

        for (int c = 0; c <= 5; c++) cyc(c, 1'b1, 40, c == 3);
        @(posedge clk); #1;
        chk("pwm_high_before_reset", int'(pwm), 1);
        chk("pending_before_reset", int'(duty_ready), 0);
        rst = 1'b0;
        #1;
        chk("async_reset_pwm", int'(pwm), 0);
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_ready", int'(duty_ready), 1);
        @(posedge clk); #2 rst = 1'b1;

        cv = 5;
        ev = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3)       cv = 0;
            else if (r < 6)  cv = cv;
            else             cv = (cv + 1) % 64;
            if ($urandom_range(0, 99) < 2) ev = !ev;
            cyc(cv, ev, int'($urandom_range(0, 63)), $urandom_range(0, 99) < 15);
            if ($urandom_range(0, 999) < 2) begin
                #1 rst = 1'b0;
                @(posedge clk); #2 rst = 1'b1;
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_from_count6.md
PWM_FROM_COUNT6 -- requirements
Module: pwm_from_count6

Interface
REQ-001 The block SHALL expose these ports, one clock domain, clock and reset first:
- clk  input  1  rising-edge clock; same clock as the upstream 6-bit counter
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- cnt  input  6  free-running count from the upstream 6-bit counter
- en  input  1  run request
- duty  input  6  new duty value, high-time in counts per 64-count period
- duty_valid  input  1  duty offer
- duty_ready  output  1  shadow register free
- pwm  output  1  registered PWM output
- busy  output  1  high when state is not IDLE
- wrap_p  output  1  period-start pulse; present only with PWM6_WRAP_PULSE_EN
REQ-002 The block SHALL have no parameters; width is fixed at 6 bits.

Function
REQ-003 The block SHALL hold cnt_q, the previous-cycle cnt; boundary = (cnt == 0) && (cnt_q != 0), evaluated combinationally each cycle.
REQ-004 The boundary rule SHALL treat a natural wrap (63 -> 0) and an upstream mid-period reset (k -> 0, k != 0) both as boundaries; cnt held at 0 SHALL yield exactly one boundary.
REQ-005 The FSM SHALL have states IDLE, ARMED, RUN and STOP with these transitions:
- IDLE -> ARMED when en = 1
- ARMED -> RUN on boundary; ARMED -> IDLE if en = 0
- RUN -> STOP when en = 0
- STOP -> RUN if en = 1 before a boundary; STOP -> IDLE on boundary with en = 0
REQ-006 Active duty duty_act SHALL update only on a boundary cycle, from the shadow when pending = 1; pending then clears.
REQ-007 duty_ready SHALL equal !pending; a transfer SHALL occur when duty_valid && duty_ready, loading shadow and setting pending.
REQ-008 When a transfer and a boundary coincide with pending = 0, the new value SHALL go to the shadow and apply at the next boundary, not the current one.
REQ-009 pwm SHALL be registered with 1-cycle latency: pwm <= (state_next in {RUN, STOP}) && (cnt < duty_act_next).
REQ-010 duty_act = 0 SHALL give pwm constantly 0; duty_act = 63 SHALL give 63 high cycles per 64; no value SHALL give 100 %.
REQ-011 The compare SHALL be unsigned 6-bit, with no wrap or extension.
REQ-012 In IDLE and ARMED, pwm SHALL be 0; duty_ready SHALL keep operating in every state.
REQ-013 busy SHALL be registered and equal (state != IDLE).

Reset
REQ-014 While rst = 0, asynchronously: state = IDLE, cnt_q = 0, shadow = 0, duty_act = 0, pending = 0, pwm = 0, busy = 0, duty_ready = 1, wrap_p = 0.
REQ-015 Reset asserted mid-period SHALL force pwm low within the same reset assertion, with no clock edge required, and SHALL discard any pending duty value.
REQ-016 After rst releases, the first boundary SHALL require cnt to leave 0 and return to it.

Configuration
REQ-017 With PWM6_WRAP_PULSE_EN defined, port wrap_p SHALL exist and pulse high for exactly 1 cycle, registered, in the cycle after each boundary seen in RUN or STOP.
REQ-018 Without PWM6_WRAP_PULSE_EN, the port wrap_p and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-019 Free-running cnt, duty = 16 offered in IDLE, en = 1 -> ARMED until cnt 63->0; then pwm high for cnt 0..15 (seen 1 cycle later), low for 16..63, repeating.
REQ-020 In RUN with duty_act = 16, offer 40 mid-period -> duty_ready drops next cycle; period keeps 16; next period has 40 high cycles; duty_ready returns high after that boundary.
REQ-021 Transfer of duty = 8 on the exact boundary cycle with pending = 0 -> the starting period uses the old duty; 8 applies one period later.
REQ-022 en = 0 at cnt = 20 in RUN -> STOP, period completes normally, IDLE at boundary, pwm 0, busy 0; a second run with en = 1 re-raised at cnt = 30 in STOP -> RUN, no gap.
REQ-023 duty 0 and duty 63 -> 0 and 63 high cycles per 64; upstream reset cnt 37 -> 0 -> one boundary, duty update applied there.
REQ-024 rst = 0 at cnt = 5 while pwm = 1 -> pwm, busy 0 immediately and pending cleared; with PWM6_WRAP_PULSE_EN, wrap_p is exactly one 1-cycle pulse per 64 cycles in RUN.
